// File: rtl/bmp_stream_writer.sv
// bmp_stream_writer: turns an RGB888 pixel stream into a complete 24-bit BMP byte stream.
module bmp_stream_writer #(
  parameter int WIDTH    = 300,
  parameter int HEIGHT   = 400,
  parameter bit TOP_DOWN = 1'b0,
  parameter string OUTFILE = "output.bmp"
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  // state  | meaning
  // IDLE   | waiting for start
  // HEADER | emitting the 54 header bytes
  // PIXEL  | phase 0: accept pixel and emit B; phase 1: G; phase 2: R
  // PAD    | emitting zero bytes up to the 4-byte row boundary
  // FLUSH  | waiting for the sink to take the final byte
  // DONE   | frame_done pulse; start is not honoured here
  // The end-of-row decision (next row or FLUSH) is taken in the cycle that loads the row's last byte.
  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_PIXEL, S_PAD, S_FLUSH, S_DONE
  } state_t;

  localparam int          PAD      = (4 - (3 * WIDTH) % 4) % 4;
  localparam int          ROWB     = 3 * WIDTH + PAD;
  localparam longint      ISZ_L    = longint'(ROWB) * longint'(HEIGHT);
  localparam logic [31:0] ISZ      = 32'(ISZ_L);
  localparam logic [31:0] FSZ      = 32'(ISZ_L + 54);
  localparam logic [31:0] WID32    = 32'(WIDTH);
  localparam logic [31:0] HGT32    = TOP_DOWN ? 32'(-HEIGHT) : 32'(HEIGHT);
  localparam logic [15:0] COL_LAST = 16'(WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(HEIGHT - 1);
  localparam logic [1:0]  PAD_LAST = 2'(PAD - 1);

  state_t      state;
  logic [5:0]  hdr_idx;
  logic [15:0] col;
  logic [15:0] row;
  logic [1:0]  phase;
  logic [1:0]  pad_cnt;
  logic [7:0]  g_q;
  logic [7:0]  r_q;
  logic [7:0]  hdr_byte;
  logic        ld;

  assign ld        = !byte_valid || byte_ready;
  assign pix_ready = (state == S_PIXEL) && (phase == 2'd0) && ld;
  assign busy      = (state != S_IDLE);

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      6'd0:  hdr_byte = 8'h42;
      6'd1:  hdr_byte = 8'h4D;
      6'd2:  hdr_byte = FSZ[7:0];
      6'd3:  hdr_byte = FSZ[15:8];
      6'd4:  hdr_byte = FSZ[23:16];
      6'd5:  hdr_byte = FSZ[31:24];
      6'd10: hdr_byte = 8'd54;
      6'd14: hdr_byte = 8'd40;
      6'd18: hdr_byte = WID32[7:0];
      6'd19: hdr_byte = WID32[15:8];
      6'd20: hdr_byte = WID32[23:16];
      6'd21: hdr_byte = WID32[31:24];
      6'd22: hdr_byte = HGT32[7:0];
      6'd23: hdr_byte = HGT32[15:8];
      6'd24: hdr_byte = HGT32[23:16];
      6'd25: hdr_byte = HGT32[31:24];
      6'd26: hdr_byte = 8'd1;
      6'd28: hdr_byte = 8'd24;
      6'd34: hdr_byte = ISZ[7:0];
      6'd35: hdr_byte = ISZ[15:8];
      6'd36: hdr_byte = ISZ[23:16];
      6'd37: hdr_byte = ISZ[31:24];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= S_IDLE;
      hdr_idx     <= '0;
      col         <= '0;
      row         <= '0;
      phase       <= '0;
      pad_cnt     <= '0;
      g_q         <= '0;
      r_q         <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      // a new load below overrides this drop of the accepted byte
      if (byte_ready) byte_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            hdr_idx <= '0;
            col     <= '0;
            row     <= '0;
            phase   <= '0;
            state   <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (ld) begin
            byte_data  <= hdr_byte;
            byte_valid <= 1'b1;
            if (hdr_idx == 6'd53) begin
              hdr_idx <= '0;
              state   <= S_PIXEL;
            end else begin
              hdr_idx <= hdr_idx + 6'd1;
            end
          end
        end
        S_PIXEL: begin
          if (phase == 2'd0) begin
            if (pix_valid && ld) begin
              byte_data  <= pix_b;
              byte_valid <= 1'b1;
              g_q        <= pix_g;
              r_q        <= pix_r;
              phase      <= 2'd1;
            end
          end else if (ld) begin
            byte_valid <= 1'b1;
            if (phase == 2'd1) begin
              byte_data <= g_q;
              phase     <= 2'd2;
            end else begin
              byte_data <= r_q;
              phase     <= 2'd0;
              if (col != COL_LAST) begin
                col <= col + 16'd1;
              end else begin
                col <= '0;
                if (PAD != 0) begin
                  pad_cnt <= PAD_LAST;
                  state   <= S_PAD;
                end else if (row == ROW_LAST) begin
                  row   <= '0;
                  state <= S_FLUSH;
                end else begin
                  row <= row + 16'd1;
                end
              end
            end
          end
        end
        S_PAD: begin
          if (ld) begin
            byte_data  <= 8'h00;
            byte_valid <= 1'b1;
            if (pad_cnt != 2'd0) begin
              pad_cnt <= pad_cnt - 2'd1;
            end else if (row == ROW_LAST) begin
              row   <= '0;
              state <= S_FLUSH;
            end else begin
              row   <= row + 16'd1;
              state <= S_PIXEL;
            end
          end
        end
        S_FLUSH: begin
          if (ld) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            state       <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
